// File: rtl/morse_decoder.sv
// morse_decoder: assembles dot/line strobes into A-Z / 0-9 character codes.
// Latency: a character is emitted GAP_CYCLES edges after its last symbol edge,
//   with a one-cycle char_valid pulse. Backpressure: none. Output is a registered pulse and is never stalled.
//
// Ports:
//   clock       in   1  system clock, all logic on posedge
//   resetn      in   1  synchronous active-low reset
//   ld_dot      in   1  dot level from the input stage (may be held high)
//   ld_line     in   1  line level from the input stage (may be held high)
//   char_valid  out  1  one-cycle pulse, char_code/char_err/char_len are new
//   char_code   out  6  0-25 = A-Z, 26-35 = digits 0-9, 63 = invalid
//   char_err    out  1  character invalid (bad pattern or overflow)
//   char_len    out  3  symbols captured (clamped at 5)
//   busy        out  1  a character is being collected
module morse_decoder #(
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ld_dot,
  input  logic       ld_line,
  output logic       char_valid,
  output logic [5:0] char_code,
  output logic       char_err,
  output logic [2:0] char_len,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [5:0]  CODE_BAD = 6'd63;
  localparam logic [2:0]  LEN_MAX  = 3'd5;

  // ---------------------------------------------------------------------------
  // Standard International Morse lookup. Dot = 0, line = 1, first symbol is the
  // most significant of the len valid bits; unused upper bits are always zero
  // because the buffer starts clean and shifts left.
  // ---------------------------------------------------------------------------
  function automatic logic [5:0] morse_lookup(input logic [2:0] len,
                                              input logic [4:0] pat);
    logic [5:0] code;
    case ({len, pat})
      // one symbol
      8'b001_00000: code = 6'd4;   // E .
      8'b001_00001: code = 6'd19;  // T -
      // two symbols
      8'b010_00000: code = 6'd8;   // I ..
      8'b010_00001: code = 6'd0;   // A .-
      8'b010_00010: code = 6'd13;  // N -.
      8'b010_00011: code = 6'd12;  // M --
      // three symbols
      8'b011_00000: code = 6'd18;  // S ...
      8'b011_00001: code = 6'd20;  // U ..-
      8'b011_00010: code = 6'd17;  // R .-.
      8'b011_00011: code = 6'd22;  // W .--
      8'b011_00100: code = 6'd3;   // D -..
      8'b011_00101: code = 6'd10;  // K -.-
      8'b011_00110: code = 6'd6;   // G --.
      8'b011_00111: code = 6'd14;  // O ---
      // four symbols
      8'b100_00000: code = 6'd7;   // H ....
      8'b100_00001: code = 6'd21;  // V ...-
      8'b100_00010: code = 6'd5;   // F ..-.
      8'b100_00100: code = 6'd11;  // L .-..
      8'b100_00110: code = 6'd15;  // P .--.
      8'b100_00111: code = 6'd9;   // J .---
      8'b100_01000: code = 6'd1;   // B -...
      8'b100_01001: code = 6'd23;  // X -..-
      8'b100_01010: code = 6'd2;   // C -.-.
      8'b100_01011: code = 6'd24;  // Y -.--
      8'b100_01100: code = 6'd25;  // Z --..
      8'b100_01101: code = 6'd16;  // Q --.-
      // five symbols: digits
      8'b101_11111: code = 6'd26;  // 0 -----
      8'b101_01111: code = 6'd27;  // 1 .----
      8'b101_00111: code = 6'd28;  // 2 ..---
      8'b101_00011: code = 6'd29;  // 3 ...--
      8'b101_00001: code = 6'd30;  // 4 ....-
      8'b101_00000: code = 6'd31;  // 5 .....
      8'b101_10000: code = 6'd32;  // 6 -....
      8'b101_11000: code = 6'd33;  // 7 --...
      8'b101_11100: code = 6'd34;  // 8 ---..
      8'b101_11110: code = 6'd35;  // 9 ----.
      default:      code = CODE_BAD;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Edge detection: a held level produces exactly one event.
  // ---------------------------------------------------------------------------
  logic ld_dot_q, ld_line_q;
  logic dot_ev, line_ev, any_ev, sym_ev, both_ev;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      ld_dot_q  <= 1'b0;
      ld_line_q <= 1'b0;
    end else begin
      ld_dot_q  <= ld_dot;
      ld_line_q <= ld_line;
    end
  end

  assign dot_ev  = ld_dot & ~ld_dot_q;
  assign line_ev = ld_line & ~ld_line_q;
  assign any_ev  = dot_ev | line_ev;
  assign sym_ev  = dot_ev ^ line_ev;
  // Simultaneous rises are ambiguous: nothing is stored, character is flagged.
  assign both_ev = dot_ev & line_ev;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   gap_done;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. An event always wins over the gap timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_ev) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (any_ev)        state_d = S_COLLECT;
        else if (gap_done) state_d = S_EMIT;
      end
      S_EMIT: begin
        state_d = any_ev ? S_COLLECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Symbol buffer and gap counter
  // ---------------------------------------------------------------------------
  logic [4:0]  pattern_q, pattern_d;
  logic [2:0]  len_q, len_d;
  logic        ovf_q, ovf_d;
  logic [15:0] gap_q, gap_d;
  logic [4:0]  base_pat;
  logic [2:0]  base_len;
  logic        base_ovf;

  assign gap_done = (gap_q == GAP_LAST);

  always_comb begin
    // Only S_COLLECT carries a partial character forward; in S_EMIT the buffer
    // has already been copied to the outputs, so a new event starts fresh.
    if (state_q == S_COLLECT) begin
      base_pat = pattern_q;
      base_len = len_q;
      base_ovf = ovf_q;
    end else begin
      base_pat = 5'd0;
      base_len = 3'd0;
      base_ovf = 1'b0;
    end

    pattern_d = base_pat;
    len_d     = base_len;
    ovf_d     = base_ovf;

    if (both_ev) begin
      ovf_d = 1'b1;
    end else if (sym_ev) begin
      if (base_len == LEN_MAX) begin
        // A sixth symbol is dropped; the character is reported as invalid.
        ovf_d = 1'b1;
      end else begin
        pattern_d = {base_pat[3:0], line_ev};
        len_d     = base_len + 3'd1;
      end
    end

    if (any_ev) begin
      gap_d = 16'd0;
    end else if ((state_q == S_COLLECT) && !gap_done) begin
      gap_d = gap_q + 16'd1;
    end else begin
      gap_d = 16'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pattern_q <= 5'd0;
      len_q     <= 3'd0;
      ovf_q     <= 1'b0;
      gap_q     <= 16'd0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      gap_q     <= gap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic. The decoded character is captured on the edge that
  // enters S_EMIT, so char_valid is high exactly while the FSM sits in S_EMIT.
  // ---------------------------------------------------------------------------
  logic       enter_emit;
  logic [5:0] code_calc;
  logic       err_calc;

  always_comb begin
    enter_emit = (state_q == S_COLLECT) && (state_d == S_EMIT);
    code_calc  = ovf_q ? CODE_BAD : morse_lookup(len_q, pattern_q);
    err_calc   = ovf_q | (code_calc == CODE_BAD);
  end

  logic       char_valid_q;
  logic [5:0] char_code_q;
  logic       char_err_q;
  logic [2:0] char_len_q;
  logic       busy_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      char_valid_q <= 1'b0;
      char_code_q  <= CODE_BAD;
      char_err_q   <= 1'b0;
      char_len_q   <= 3'd0;
      busy_q       <= 1'b0;
    end else begin
      char_valid_q <= enter_emit;
      busy_q       <= (state_d == S_COLLECT);
      if (enter_emit) begin
        char_code_q <= code_calc;
        char_err_q  <= err_calc;
        char_len_q  <= len_q;
      end
    end
  end

  assign char_valid = char_valid_q;
  assign char_code  = char_code_q;
  assign char_err   = char_err_q;
  assign char_len   = char_len_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: stimulus pushes expected characters
// (code, err, len, emit cycle); a monitor pops one per char_valid pulse.
module tb_morse_decoder;

  localparam int G = 8;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       ld_dot = 1'b0;
  logic       ld_line = 1'b0;
  logic       char_valid;
  logic [5:0] char_code;
  logic       char_err;
  logic [2:0] char_len;
  logic       busy;

  morse_decoder #(.GAP_CYCLES(G)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .ld_dot     (ld_dot),
    .ld_line    (ld_line),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_err   (char_err),
    .char_len   (char_len),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  // Number of the most recent rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] code;
    logic       err;
    logic [2:0] len;
    int         at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   done   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle pulse; cap returns the edge number that captures it.
  task automatic sym(input bit dot, input bit line, output int cap);
    ld_dot  = dot;
    ld_line = line;
    tick();
    cap     = cyc;
    ld_dot  = 1'b0;
    ld_line = 1'b0;
    tick();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input logic [5:0] code, input logic err, input logic [2:0] len, input int at);
    exp_t e;
    e.code = code;
    e.err  = err;
    e.len  = len;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check({name, "_drain"}, sb.size(), 0);
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want completion");
    $fatal(1);
  end

  initial begin
    fork
      // Monitor
      begin
        while (!done) begin
          @(negedge clock);
          if (char_valid === 1'b1) begin
            if (sb.size() == 0) begin
              n_vec++;
              n_miss++;
              $display("FAIL unexpected_valid: got pulse code %0d at cycle %0d, want no pulse",
                       char_code, cyc);
            end else begin
              mon_e = sb.pop_front();
              check("code",  char_code, mon_e.code);
              check("err",   char_err,  mon_e.err);
              check("len",   char_len,  mon_e.len);
              check("cycle", cyc,       mon_e.at);
            end
          end
        end
      end
      // Stimulus
      begin
        int c, c2;
        repeat (3) tick();
        check("rst_valid", char_valid, 0);
        check("rst_code",  char_code,  63);
        check("rst_err",   char_err,   0);
        check("rst_len",   char_len,   0);
        check("rst_busy",  busy,       0);
        resetn = 1'b1;
        repeat (2) tick();

        // A: dot, line two cycles apart
        sym(1'b1, 1'b0, c);
        sym(1'b0, 1'b1, c);
        check("A_busy", busy, 1);
        push(6'd0, 1'b0, 3'd2, c + G);
        drain("A");
        check("idle_busy", busy, 0);

        // Held dot for 20 cycles -> single E
        ld_dot = 1'b1;
        tick();
        c = cyc;
        push(6'd4, 1'b0, 3'd1, c + G);
        repeat (19) tick();
        ld_dot = 1'b0;
        tick();
        drain("held");

        // Five lines -> digit 0
        for (int i = 0; i < 5; i++) sym(1'b0, 1'b1, c);
        push(6'd26, 1'b0, 3'd5, c + G);
        drain("zero");

        // Six lines -> overflow
        for (int i = 0; i < 6; i++) sym(1'b0, 1'b1, c);
        push(6'd63, 1'b1, 3'd5, c + G);
        drain("ovf");

        // ..-- is not a character
        sym(1'b1, 1'b0, c);
        sym(1'b1, 1'b0, c);
        sym(1'b0, 1'b1, c);
        sym(1'b0, 1'b1, c);
        push(6'd63, 1'b1, 3'd4, c + G);
        drain("bad");

        // Dot exactly on the timeout edge extends: line+dot = N
        sym(1'b0, 1'b1, c);
        wait_until(c + G - 1);
        sym(1'b1, 1'b0, c2);
        push(6'd13, 1'b0, 3'd2, c2 + G);
        drain("extend");

        // Back-to-back: dot captured in the S_EMIT cycle of T
        sym(1'b0, 1'b1, c);
        push(6'd19, 1'b0, 3'd1, c + G);
        wait_until(c + G);
        sym(1'b1, 1'b0, c2);
        push(6'd4, 1'b0, 3'd1, c2 + G);
        drain("b2b");

        // Reset mid-character discards it
        sym(1'b1, 1'b0, c);
        sym(1'b1, 1'b0, c);
        sym(1'b1, 1'b0, c);
        check("mid_busy", busy, 1);
        resetn = 1'b0;
        tick();
        check("mrst_valid", char_valid, 0);
        check("mrst_code",  char_code,  63);
        check("mrst_err",   char_err,   0);
        check("mrst_len",   char_len,   0);
        check("mrst_busy",  busy,       0);
        resetn = 1'b1;
        repeat (3 * G) tick();
        sym(1'b0, 1'b1, c);
        push(6'd19, 1'b0, 3'd1, c + G);
        drain("post_rst");

        // Simultaneous dot+line rise
        sym(1'b1, 1'b1, c);
        push(6'd63, 1'b1, 3'd0, c + G);
        drain("simul");

        done = 1'b1;
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
